// File: rtl/rot_seq_8bit.sv
// ---------------------------------------------------------------------------
// rot_seq_8bit
//
// Sequential inverse of the combinational left/right rotate stage. It turns
// a rotated word back into its original by rotating it one bit per clock, so
// no barrel network is needed. It is handshaked on both sides. The input side
// accepts only in IDLE. The output side presents the result in DONE until
// the consumer takes it.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   a          in   word to rotate, sampled on accept
//   lr         in   direction being undone: 0 = undo left (rotate right),
//                   1 = undo right (rotate left), sampled on accept
//   amt        in   rotation distance 0..7, sampled on accept
//   in_valid   in   request valid
//   in_ready   out  high only in IDLE
//   y          out  result word, meaningful while out_valid = 1
//   out_valid  out  high only in DONE
//   out_ready  in   consumer accepts the result
//   busy       out  high in SHIFT or DONE
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; in_ready = 1
// SHIFT | one 1-bit rotate per clock until cnt reaches zero
// DONE  | result presented on y with out_valid = 1 until out_ready
// ---------------------------------------------------------------------------
module rot_seq_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             lr,
    input  logic [2:0]       amt,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [2:0]       cnt_q,   cnt_d;
    logic             dir_q,   dir_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = a;
                    cnt_d   = amt;
                    dir_d   = lr;
                    state_d = (amt == 3'd0) ? ST_DONE : ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (dir_q) begin
                    data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                end else begin
                    data_d = {data_q[0], data_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - 3'd1;
                // cnt is never 0 in SHIFT; the <= also escapes an
                // upset-corrupted zero count instead of looping 8 more times.
                if (cnt_q <= 3'd1) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= 3'd0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    // All outputs are decoded from registered state. No combinational path
    // exists from the handshake inputs to the handshake outputs.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign y         = data_q;

endmodule

// File: tb/tb_rot_seq_8bit.sv
module tb_rot_seq_8bit;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic       lr;
    logic [2:0] amt;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] y;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int n_cmp;
    int n_err;

    rot_seq_8bit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .lr        (lr),
        .amt       (amt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] rotr(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} >> n;
        return t[7:0];
    endfunction

    // One full transaction with out_ready held high. Checks latency, result,
    // busy duration and the return to IDLE.
    task automatic do_txn(input string tag, input logic [7:0] a_v, input logic lr_v,
                          input logic [2:0] amt_v, input logic [7:0] exp_y);
        int lat;
        int busy_n;
        a         = a_v;
        lr        = lr_v;
        amt       = amt_v;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check_eq({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        // Scramble inputs after accept; they must have no effect.
        a   = ~a_v;
        lr  = ~lr_v;
        amt = ~amt_v;
        lat    = 0;
        busy_n = 0;
        while (!out_valid && lat < 20) begin
            if (busy) busy_n++;
            step();
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(amt_v));
        check_eq({tag, "_y"}, 32'(y), 32'(exp_y));
        if (busy) busy_n++;
        step();
        check_eq({tag, "_busy_cycles"}, 32'(busy_n), 32'(amt_v) + 32'd1);
        check_eq({tag, "_idle_after"}, {29'd0, in_ready, out_valid, busy}, 32'b100);
    endtask

    initial begin
        int ov_seen;
        int rt_err_before;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        a         = 8'h00;
        lr        = 1'b0;
        amt       = 3'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        step();
        step();
        rst = 1'b0;
        check_eq("reset_y", 32'(y), 32'h00);
        check_eq("reset_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);

        // Reset mid-SHIFT discards the partial result.
        a        = 8'hC3;
        lr       = 1'b1;
        amt      = 3'd5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check_eq("midop_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_eq("midop_rst_y", 32'(y), 32'h00);
        check_eq("midop_rst_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
        ov_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) ov_seen++;
        end
        check_eq("midop_never_presented", 32'(ov_seen), 32'd0);

        // Rotate right (undo left).
        a         = 8'hB1;
        lr        = 1'b0;
        amt       = 3'd3;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        ov_seen  = 0;
        for (int i = 1; i <= 2; i++) begin
            if (out_valid) ov_seen++;
            step();
        end
        if (out_valid) ov_seen++;
        check_eq("ror_early_valid", 32'(ov_seen), 32'd0);
        step();
        check_eq("ror_valid_T4", 32'(out_valid), 32'd1);
        check_eq("ror_y", 32'(y), 32'h36);
        step();
        check_eq("ror_T5_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);

        // Rotate left with a stalled consumer and an ignored request.
        a         = 8'hB1;
        lr        = 1'b1;
        amt       = 3'd3;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        check_eq("rol_valid_T4", 32'(out_valid), 32'd1);
        check_eq("rol_y", 32'(y), 32'h8D);
        ov_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                a        = 8'hFF;
                lr       = 1'b0;
                amt      = 3'd0;
                in_valid = 1'b1;
            end
            step();
            in_valid = 1'b0;
            if (!out_valid || y != 8'h8D || in_ready) ov_seen++;
        end
        check_eq("stall_hold_bad_cycles", 32'(ov_seen), 32'd0);
        check_eq("stall_y", 32'(y), 32'h8D);
        out_ready = 1'b1;
        step();
        check_eq("stall_release_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);

        // Distance boundaries.
        do_txn("amt0",     8'h5A, 1'b0, 3'd0, 8'h5A);
        do_txn("rol7",     8'h01, 1'b1, 3'd7, 8'h80);
        do_txn("ror7",     8'h01, 1'b0, 3'd7, 8'h02);
        do_txn("amt0_lr1", 8'hA5, 1'b1, 3'd0, 8'hA5);

        // Round trip against the combinational rotator model.
        rt_err_before = n_err;
        for (int av = 0; av < 256; av++) begin
            for (int d = 0; d < 2; d++) begin
                for (int n = 0; n < 8; n++) begin
                    if (n_err - rt_err_before < 20) begin
                        do_txn($sformatf("rt_a%0h_lr%0d_n%0d", av, d, n),
                               (d == 0) ? rotl(8'(av), n) : rotr(8'(av), n),
                               1'(d), 3'(n), 8'(av));
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
